tdm_slot_sched: RTL and testbench
=================================

Name: tdm_slot_sched

Overview:
- Time-division slot scheduler directly downstream of the one-hot ring counter.
- Takes the rotating one-hot phase vector as a slot enable and grants exactly one of N input channels per cycle.
- Moves the granted word into a single-entry registered output stage with valid/ready handshake.
- Checks phase integrity (one-hot), counts violations, and blocks all transfers on a bad phase.

Parameters:
- N, 4, number of channels/slots; must match ring counter width; N >= 2.
- W, 8, data width per channel.
- CW, $clog2(N), channel index width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- phase  input  N  one-hot slot vector from ring counter; bit i set = slot i active.
- in_valid  input  N  per-channel valid.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_ready  output  N  per-channel ready (combinational).
- out_valid  output  1  output stage holds a word.
- out_data  output  W  held word.
- out_ch  output  CW  source channel of held word.
- out_ready  input  1  consumer accepts word.
- err_clr  input  1  clears err_sticky.
- err_pulse  output  1  registered, 1 cycle after any phase violation.
- err_sticky  output  1  set on violation, held until rst or err_clr.
- err_cnt  output  8  saturating count of violation cycles.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_ch=0, err_pulse=0, err_sticky=0, err_cnt=0. rst asserted mid-transfer discards the held word; no output next cycle.
- onehot = phase has exactly one bit set. slot = index of that bit.
- space = !out_valid | out_ready.
- in_ready[i] = phase[i] & onehot & space. Independent of in_valid. At most one bit high.
- accept = onehot & space & in_valid[slot].
  - On accept: out_data <= in_data[slot], out_ch <= slot, out_valid <= 1.
  - Latency: input handshake to out_valid is 1 cycle.
- If out_valid & out_ready & !accept: out_valid <= 0.
- If out_valid & !out_ready: out_data and out_ch hold stable; all in_ready are 0.
- Simultaneous drain and accept: throughput is 1 word/cycle with no bubble.
- Output stage FSM, 2 states:
  - EMPTY -> FULL on accept.
  - FULL -> FULL on accept while out_ready, or while stalled.
  - FULL -> EMPTY on out_ready without accept.
- Phase violation (phase == 0 or more than one bit set):
  - No accept; in_ready all 0.
  - err_pulse=1 next cycle.
  - err_sticky <= 1.
  - err_cnt increments, saturating at 255.
  - The held output word is unaffected and may still drain.
- err_clr and a violation in the same cycle: the violation wins and err_sticky stays 1. err_clr does not clear err_cnt.
- Slot not valid (in_valid[slot]=0): the slot is lost and no wait occurs. The next phase serves the next channel.
- Ring rotation order is 0 -> N-1 -> N-2 -> ... -> 1 -> 0. The block does not depend on this order unless the optional feature is enabled.

Optional Feature:
- Macro: TDM_SLOT_SCHED_SEQ_CHK_EN.
- Defined: adds a lock FSM with states UNLOCKED and LOCKED, plus a registered expected-phase vector.
  - UNLOCKED -> LOCKED on the first one-hot phase. exp <= rotate-right(phase) by 1.
  - In LOCKED, phase != exp counts as a violation (err_pulse/err_sticky/err_cnt as above), blocks accept, and returns the FSM to UNLOCKED.
  - Accepts are permitted only in LOCKED with phase == exp, or on the locking cycle itself.
  - rst -> UNLOCKED.
- Undefined: no sequence check; only the one-hot check applies.

Test Plan:
1. rst 2 cycles, phase rotates 0001 -> 1000 -> 0100 -> 0010, all in_valid=1, in_data ch0..3 = 0xA0..0xA3, out_ready=1 -> out_data sequence A0, A3, A2, A1 with out_ch 0, 3, 2, 1, one cycle after each grant, no bubbles.
2. Hold out_ready=0 after the first word (A0) -> out_valid stays 1, out_data=A0 stable, in_ready=0000. Raise out_ready -> A0 drains and the next slot's word is captured in the same cycle.
3. phase=0110 for 1 cycle, then 0000 for 1 cycle -> no accept, err_pulse high on the 2 following cycles, err_sticky=1, err_cnt=2. err_clr then drops err_sticky; err_cnt stays 2.
4. Drive 300 consecutive bad-phase cycles -> err_cnt saturates at 255. Assert err_clr together with a bad phase -> err_sticky remains 1.
5. Assert rst while out_valid=1, out_ready=0 -> out_valid=0 next cycle, all error state 0.
6. With TDM_SLOT_SCHED_SEQ_CHK_EN: phase 0001 -> 1000 -> 0010 (skip) -> violation flagged, no accept on the 0010 cycle. The next one-hot phase relocks and accepts resume.

Source files
------------

// File: rtl/tdm_slot_sched_if.sv
// Handshake bundle for tdm_slot_sched: N producer channels in, one registered word out.
// The design uses the slave modport; the producers/consumer side uses master.
interface tdm_slot_sched_if #(
    parameter int N = 4,
    parameter int W = 8
);
    localparam int CW = $clog2(N);

    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [CW-1:0]  out_ch;
    logic           out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/tdm_slot_sched.sv
// Time-division slot scheduler: grants the channel selected by a one-hot ring phase into a
// single-entry output stage. Optional ring-order lock check via TDM_SLOT_SCHED_SEQ_CHK_EN.
module tdm_slot_sched #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int CW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   phase,
    tdm_slot_sched_if.slave bus,
    input  logic           err_clr,
    output logic           err_pulse,
    output logic           err_sticky,
    output logic [7:0]     err_cnt
);
    localparam int OW = $clog2(N + 1);

    typedef enum logic {EMPTY, FULL} out_state_t;

    out_state_t     out_state;
    logic [W-1:0]   data_q;
    logic [CW-1:0]  ch_q;
    logic [OW-1:0]  ones;
    logic [CW-1:0]  slot;
    logic           onehot;
    logic           seq_bad;
    logic           violation;
    logic           space;
    logic           accept;

    always_comb begin
        ones = '0;
        slot = '0;
        for (int i = 0; i < N; i++) begin
            if (phase[i]) begin
                ones = ones + OW'(1);
                slot = CW'(i);
            end
        end
    end

    assign onehot    = (ones == OW'(1));
    assign violation = !onehot || seq_bad;
    assign space     = (out_state == EMPTY) || bus.out_ready;
    assign accept    = !violation && space && bus.in_valid[slot];

    always_comb begin
        bus.in_ready = '0;
        if (!violation && space) begin
            bus.in_ready = phase;
        end
    end

`ifdef TDM_SLOT_SCHED_SEQ_CHK_EN
    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

    lock_state_t    lock_state;
    logic [N-1:0]   exp_phase;

    assign seq_bad = (lock_state == LOCKED) && (phase != exp_phase);

    // Any good phase (re)locks and predicts the next ring position; any bad one drops the lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_state <= UNLOCKED;
            exp_phase  <= '0;
        end else if (violation) begin
            lock_state <= UNLOCKED;
        end else begin
            lock_state <= LOCKED;
            exp_phase  <= {phase[0], phase[N-1:1]};
        end
    end
`else
    assign seq_bad = 1'b0;
`endif

    // Accept while FULL only happens when the consumer drains in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_state <= EMPTY;
            data_q    <= '0;
            ch_q      <= '0;
        end else begin
            case (out_state)
                EMPTY: begin
                    if (accept) begin
                        out_state <= FULL;
                        data_q    <= bus.in_data[slot*W +: W];
                        ch_q      <= slot;
                    end
                end
                FULL: begin
                    if (accept) begin
                        data_q <= bus.in_data[slot*W +: W];
                        ch_q   <= slot;
                    end else if (bus.out_ready) begin
                        out_state <= EMPTY;
                    end
                end
                default: out_state <= EMPTY;
            endcase
        end
    end

    assign bus.out_valid = (out_state == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;

    // A violation in the same cycle as err_clr keeps the sticky flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else begin
            err_pulse <= violation;
            if (violation) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
            if (violation && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_tdm_slot_sched.sv
// Self-checking bench for tdm_slot_sched: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the scheduling rules.
module tb_tdm_slot_sched;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = $clog2(N);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] phase = '0;
    logic         err_clr = 1'b0;
    logic         err_pulse;
    logic         err_sticky;
    logic [7:0]   err_cnt;

    int checks = 0;
    int errors = 0;

    logic          m_valid = 1'b0;
    logic [W-1:0]  m_data = '0;
    logic [CW-1:0] m_ch = '0;
    logic          m_pulse = 1'b0;
    logic          m_sticky = 1'b0;
    int            m_cnt = 0;
`ifdef TDM_SLOT_SCHED_SEQ_CHK_EN
    logic          m_locked = 1'b0;
    logic [N-1:0]  m_exp = '0;
`endif

    tdm_slot_sched_if #(.N(N), .W(W)) bus ();

    tdm_slot_sched #(.N(N), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .phase      (phase),
        .bus        (bus),
        .err_clr    (err_clr),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] rotr(input logic [N-1:0] p);
        return {p[0], p[N-1:1]};
    endfunction

    // Rules view of the current cycle: is the phase bad, which slot, what may be granted.
    task automatic model_eval(output logic viol, output logic [N-1:0] rdy, output int slot);
        slot = 0;
        for (int i = 0; i < N; i++) if (phase[i]) slot = i;
        viol = ($countones(phase) != 1);
`ifdef TDM_SLOT_SCHED_SEQ_CHK_EN
        if (m_locked && phase != m_exp) viol = 1'b1;
`endif
        rdy = (!viol && (!m_valid || bus.out_ready)) ? phase : '0;
    endtask

    task automatic tick;
        logic viol;
        logic [N-1:0] rdy;
        int slot;
        model_eval(viol, rdy, slot);
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_data = '0; m_ch = '0;
            m_pulse = 1'b0; m_sticky = 1'b0; m_cnt = 0;
`ifdef TDM_SLOT_SCHED_SEQ_CHK_EN
            m_locked = 1'b0; m_exp = '0;
`endif
        end else begin
            if (rdy != '0 && bus.in_valid[slot]) begin
                m_valid = 1'b1;
                m_data  = bus.in_data[slot*W +: W];
                m_ch    = CW'(slot);
            end else if (bus.out_ready) begin
                m_valid = 1'b0;
            end
            m_pulse = viol;
            if (viol) m_sticky = 1'b1;
            else if (err_clr) m_sticky = 1'b0;
            if (viol && m_cnt < 255) m_cnt++;
`ifdef TDM_SLOT_SCHED_SEQ_CHK_EN
            m_locked = !viol;
            if (!viol) m_exp = rotr(phase);
`endif
        end
        #1;
    endtask

    task automatic load_pattern;
        bus.in_valid = '1;
        for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = W'(8'hA0 + i);
    endtask

    task automatic test_reset;
        rst = 1'b1; phase = 4'b0001; err_clr = 1'b0; bus.out_ready = 1'b1;
        bus.in_valid = '1;
        for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = W'($urandom);
        tick(); tick();
        checks += 6;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=0", bus.out_valid); end
        if (bus.out_data !== '0) begin errors++; $display("[TB] FAIL reset_data got=%h exp=0", bus.out_data); end
        if (bus.out_ch !== '0) begin errors++; $display("[TB] FAIL reset_ch got=%0d exp=0", bus.out_ch); end
        if (err_pulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_pulse got=%b exp=0", err_pulse); end
        if (err_sticky !== 1'b0) begin errors++; $display("[TB] FAIL reset_sticky got=%b exp=0", err_sticky); end
        if (err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL reset_cnt got=%0d exp=0", err_cnt); end
        rst = 1'b0;
    endtask

    task automatic test_rotation;
        logic [N-1:0] ph [4] = '{4'b0001, 4'b1000, 4'b0100, 4'b0010};
        logic [W-1:0] ed [4] = '{8'hA0, 8'hA3, 8'hA2, 8'hA1};
        int           ec [4] = '{0, 3, 2, 1};
        load_pattern();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            phase = ph[k];
            #1;
            checks++;
            if (bus.in_ready !== ph[k]) begin errors++; $display("[TB] FAIL rot_ready[%0d] got=%b exp=%b", k, bus.in_ready, ph[k]); end
            tick();
            checks += 3;
            if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL rot_valid[%0d] got=%b exp=1", k, bus.out_valid); end
            if (bus.out_data !== ed[k]) begin errors++; $display("[TB] FAIL rot_data[%0d] got=%h exp=%h", k, bus.out_data, ed[k]); end
            if (bus.out_ch !== CW'(ec[k])) begin errors++; $display("[TB] FAIL rot_ch[%0d] got=%0d exp=%0d", k, bus.out_ch, ec[k]); end
        end
    endtask

    task automatic test_stall;
        logic [N-1:0] ph [2] = '{4'b1000, 4'b0100};
        phase = 4'b0001;
        tick();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            phase = ph[k];
            #1;
            checks++;
            if (bus.in_ready !== '0) begin errors++; $display("[TB] FAIL stall_ready[%0d] got=%b exp=0000", k, bus.in_ready); end
            tick();
            checks += 3;
            if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid[%0d] got=%b exp=1", k, bus.out_valid); end
            if (bus.out_data !== 8'hA0) begin errors++; $display("[TB] FAIL stall_data[%0d] got=%h exp=a0", k, bus.out_data); end
            if (bus.out_ch !== CW'(0)) begin errors++; $display("[TB] FAIL stall_ch[%0d] got=%0d exp=0", k, bus.out_ch); end
        end
        bus.out_ready = 1'b1;
        phase = 4'b0010;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0010) begin errors++; $display("[TB] FAIL release_ready got=%b exp=0010", bus.in_ready); end
        tick();
        checks += 3;
        if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL release_valid got=%b exp=1", bus.out_valid); end
        if (bus.out_data !== 8'hA1) begin errors++; $display("[TB] FAIL release_data got=%h exp=a1", bus.out_data); end
        if (bus.out_ch !== CW'(1)) begin errors++; $display("[TB] FAIL release_ch got=%0d exp=1", bus.out_ch); end
    endtask

    task automatic test_bad_phase;
        logic [N-1:0] ph [2] = '{4'b0110, 4'b0000};
        bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            phase = ph[k];
            #1;
            checks++;
            if (bus.in_ready !== '0) begin errors++; $display("[TB] FAIL bad_ready[%0d] got=%b exp=0000", k, bus.in_ready); end
            tick();
            checks += 2;
            if (err_pulse !== 1'b1) begin errors++; $display("[TB] FAIL bad_pulse[%0d] got=%b exp=1", k, err_pulse); end
            if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL bad_noaccept[%0d] got=%b exp=0", k, bus.out_valid); end
        end
        checks += 2;
        if (err_sticky !== 1'b1) begin errors++; $display("[TB] FAIL bad_sticky got=%b exp=1", err_sticky); end
        if (err_cnt !== 8'd2) begin errors++; $display("[TB] FAIL bad_cnt got=%0d exp=2", err_cnt); end
        phase = 4'b0001; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks += 4;
        if (err_sticky !== 1'b0) begin errors++; $display("[TB] FAIL clr_sticky got=%b exp=0", err_sticky); end
        if (err_cnt !== 8'd2) begin errors++; $display("[TB] FAIL clr_cnt got=%0d exp=2", err_cnt); end
        if (err_pulse !== 1'b0) begin errors++; $display("[TB] FAIL clr_pulse got=%b exp=0", err_pulse); end
        if (bus.out_data !== 8'hA0) begin errors++; $display("[TB] FAIL resume_data got=%h exp=a0", bus.out_data); end
    endtask

    task automatic test_saturate;
        logic [N-1:0] p;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 300; k++) begin
            do p = N'($urandom); while ($countones(p) == 1);
            phase = p;
            tick();
        end
        checks += 2;
        if (err_cnt !== 8'd255) begin errors++; $display("[TB] FAIL sat_cnt got=%0d exp=255", err_cnt); end
        if (err_sticky !== 1'b1) begin errors++; $display("[TB] FAIL sat_sticky got=%b exp=1", err_sticky); end
        phase = 4'b0011; err_clr = 1'b1;
        tick();
        checks += 3;
        if (err_sticky !== 1'b1) begin errors++; $display("[TB] FAIL clr_vs_viol_sticky got=%b exp=1", err_sticky); end
        if (err_cnt !== 8'd255) begin errors++; $display("[TB] FAIL sat_hold_cnt got=%0d exp=255", err_cnt); end
        if (err_pulse !== 1'b1) begin errors++; $display("[TB] FAIL clr_vs_viol_pulse got=%b exp=1", err_pulse); end
        phase = 4'b0001;
        tick();
        err_clr = 1'b0;
        checks++;
        if (err_sticky !== 1'b0) begin errors++; $display("[TB] FAIL sat_clr_sticky got=%b exp=0", err_sticky); end
    endtask

    task automatic test_random;
        logic [N-1:0] ring;
        logic         viol;
        logic [N-1:0] rdy;
        int           slot;
        rst = 1'b1; tick(); rst = 1'b0;
        ring = 4'b0001;
        for (int k = 0; k < 400; k++) begin
            phase = ($urandom_range(0, 7) == 0) ? N'($urandom) : ring;
            ring = rotr(ring);
            bus.in_valid  = N'($urandom);
            for (int i = 0; i < N; i++) bus.in_data[i*W +: W] = W'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            err_clr       = ($urandom_range(0, 15) == 0);
            #1;
            model_eval(viol, rdy, slot);
            checks++;
            if (bus.in_ready !== rdy) begin errors++; $display("[TB] FAIL rnd_ready[%0d] got=%b exp=%b", k, bus.in_ready, rdy); end
            tick();
            checks += 6;
            if (bus.out_valid !== m_valid) begin errors++; $display("[TB] FAIL rnd_valid[%0d] got=%b exp=%b", k, bus.out_valid, m_valid); end
            if (bus.out_data !== m_data) begin errors++; $display("[TB] FAIL rnd_data[%0d] got=%h exp=%h", k, bus.out_data, m_data); end
            if (bus.out_ch !== m_ch) begin errors++; $display("[TB] FAIL rnd_ch[%0d] got=%0d exp=%0d", k, bus.out_ch, m_ch); end
            if (err_pulse !== m_pulse) begin errors++; $display("[TB] FAIL rnd_pulse[%0d] got=%b exp=%b", k, err_pulse, m_pulse); end
            if (err_sticky !== m_sticky) begin errors++; $display("[TB] FAIL rnd_sticky[%0d] got=%b exp=%b", k, err_sticky, m_sticky); end
            if (err_cnt !== 8'(m_cnt)) begin errors++; $display("[TB] FAIL rnd_cnt[%0d] got=%0d exp=%0d", k, err_cnt, m_cnt); end
        end
        err_clr = 1'b0;
    endtask

    task automatic test_reset_mid;
        rst = 1'b1; tick(); rst = 1'b0;
        load_pattern();
        bus.out_ready = 1'b0;
        phase = 4'b0001; tick();
        phase = 4'b0000; tick();
        checks += 2;
        if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL pre_rst_valid got=%b exp=1", bus.out_valid); end
        if (err_sticky !== 1'b1) begin errors++; $display("[TB] FAIL pre_rst_sticky got=%b exp=1", err_sticky); end
        rst = 1'b1; tick(); rst = 1'b0;
        checks += 4;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got=%b exp=0", bus.out_valid); end
        if (err_pulse !== 1'b0) begin errors++; $display("[TB] FAIL midrst_pulse got=%b exp=0", err_pulse); end
        if (err_sticky !== 1'b0) begin errors++; $display("[TB] FAIL midrst_sticky got=%b exp=0", err_sticky); end
        if (err_cnt !== 8'd0) begin errors++; $display("[TB] FAIL midrst_cnt got=%0d exp=0", err_cnt); end
        bus.in_valid = '0; phase = 4'b0001; tick();
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL postrst_valid got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_sequence;
        rst = 1'b1; tick(); rst = 1'b0;
        load_pattern();
        bus.out_ready = 1'b1;
        phase = 4'b0001; tick();
        phase = 4'b1000; tick();
        checks++;
        if (bus.out_data !== 8'hA3) begin errors++; $display("[TB] FAIL seq_pre_data got=%h exp=a3", bus.out_data); end
        phase = 4'b0010;
        #1;
`ifdef TDM_SLOT_SCHED_SEQ_CHK_EN
        checks++;
        if (bus.in_ready !== '0) begin errors++; $display("[TB] FAIL seq_skip_ready got=%b exp=0000", bus.in_ready); end
        tick();
        checks += 3;
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL seq_skip_valid got=%b exp=0", bus.out_valid); end
        if (err_pulse !== 1'b1) begin errors++; $display("[TB] FAIL seq_skip_pulse got=%b exp=1", err_pulse); end
        if (err_cnt !== 8'd1) begin errors++; $display("[TB] FAIL seq_skip_cnt got=%0d exp=1", err_cnt); end
        phase = 4'b0001;
        #1;
        checks++;
        if (bus.in_ready !== 4'b0001) begin errors++; $display("[TB] FAIL seq_relock_ready got=%b exp=0001", bus.in_ready); end
        tick();
        checks += 3;
        if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL seq_relock_valid got=%b exp=1", bus.out_valid); end
        if (bus.out_data !== 8'hA0) begin errors++; $display("[TB] FAIL seq_relock_data got=%h exp=a0", bus.out_data); end
        if (err_pulse !== 1'b0) begin errors++; $display("[TB] FAIL seq_relock_pulse got=%b exp=0", err_pulse); end
`else
        checks++;
        if (bus.in_ready !== 4'b0010) begin errors++; $display("[TB] FAIL noseq_ready got=%b exp=0010", bus.in_ready); end
        tick();
        checks += 3;
        if (bus.out_data !== 8'hA1) begin errors++; $display("[TB] FAIL noseq_data got=%h exp=a1", bus.out_data); end
        if (bus.out_ch !== CW'(1)) begin errors++; $display("[TB] FAIL noseq_ch got=%0d exp=1", bus.out_ch); end
        if (err_pulse !== 1'b0) begin errors++; $display("[TB] FAIL noseq_pulse got=%b exp=0", err_pulse); end
`endif
    endtask

    initial begin
        bus.in_valid  = '0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_rotation();
        test_stall();
        test_bad_phase();
        test_saturate();
        test_random();
        test_reset_mid();
        test_sequence();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
